lsu_mem_master: RTL

// - Processor-side initiator for the word-organised synchronous data memory: turns byte-addressed
//   RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into en_mem/mem_addr/mem_wdata/mem_wmask cycles.
// - Aligns store data, builds byte masks, waits out the 1-cycle read latency, extracts and extends load data.
// - Sits between the core's execute/memory stage and the data memory; one transaction outstanding.

---
 rtl/lsu_mem_master.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-organised synchronous data memory.
// One transaction in flight; handles lane alignment, byte masks and load extension.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        en_mem,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        en_mem_q, en_mem_d;
  logic        mem_rstrb_q, mem_rstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;

  logic        illegal_f3, misaligned, out_of_range, req_err;
  logic [31:0] store_wdata;
  logic [3:0]  store_wmask;
  logic [31:0] load_shifted, load_data;

  // Request legality, evaluated on the live request while idle.
  always_comb begin
    illegal_f3 = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
      3'b100, 3'b101:         illegal_f3 = req_we;
      default:                illegal_f3 = 1'b1;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    req_err      = illegal_f3 || misaligned || out_of_range;
  end

  always_comb begin
    store_wdata = req_wdata;
    store_wmask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        store_wdata = {4{req_wdata[7:0]}};
        store_wmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        store_wdata = {2{req_wdata[15:0]}};
        store_wmask = 4'b0011 << req_addr[1:0];
      end
      default: begin
        store_wdata = req_wdata;
        store_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b100:  load_data = {24'b0, load_shifted[7:0]};
      3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_data = {16'b0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'b0;
    en_mem_d     = 1'b0;
    mem_rstrb_d  = 1'b0;
    mem_wmask_d  = 4'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_err) begin
            // Faulting requests never touch the memory port.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = StResp;
          end else begin
            en_mem_d    = 1'b1;
            mem_addr_d  = {2'b00, req_addr[31:2]};
            mem_rstrb_d = !req_we;
            if (req_we) begin
              mem_wdata_d = store_wdata;
              mem_wmask_d = store_wmask;
            end
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
        state_d      = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b0;
      off_q        <= 2'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
      en_mem_q     <= 1'b0;
      mem_rstrb_q  <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
      mem_wmask_q  <= 4'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      en_mem_q     <= en_mem_d;
      mem_rstrb_q  <= mem_rstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign en_mem     = en_mem_q;
  assign mem_rstrb  = mem_rstrb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;

endmodule
